hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Stall/flush controller complementing the ForwardingUnit: where forwarding cannot
//  resolve a hazard, this block freezes or bubbles the 5-stage pipeline. Handles
//  load-use stalls, data-memory wait freezes and branch-taken flushes. Drives the
//  write enables of the PC, IF/ID, ID/EX and EX/MEM registers and a stall perf counter.
// PARAMETERS
//  LOAD_STALL   1    bubble cycles inserted per load-use hazard (1..15)
//  MEM_TIMEOUT  255  wait cycles before mem_timeout is flagged (1..255)
//  CNT_W        16   width of stall_count (saturating)
// PORTS
//  clk          in   1      rising-edge clock, single clock domain
//  reset        in   1      synchronous, active-high
//  Rs1          in   5      ID-stage source register 1
//  Rs2          in   5      ID-stage source register 2
//  UseRs1       in   1      ID instruction reads Rs1
//  UseRs2       in   1      ID instruction reads Rs2
//  Rd1          in   5      EX-stage destination register
//  MemRead1     in   1      EX-stage instruction is a load
//  BranchTaken  in   1      EX-stage branch/jump resolved taken
//  MemReq       in   1      MEM-stage access in progress
//  MemReady     in   1      data memory completes access this cycle
//  PCWrite      out  1      PC register enable
//  IFIDWrite    out  1      IF/ID register enable
//  IFIDFlush    out  1      IF/ID loads NOP
//  IDEXWrite    out  1      ID/EX register enable
//  IDEXFlush    out  1      ID/EX loads bubble (control zeroed)
//  EXMEMWrite   out  1      EX/MEM register enable (also gates MEM/WB)
//  mem_timeout  out  1      sticky: a memory wait exceeded MEM_TIMEOUT
//  stall_count  out  CNT_W  cycles with PCWrite=0, saturates at all-ones
// BEHAVIOUR
//  States: RUN, LU_STALL, MEM_WAIT. Reset: state=RUN, lu_cnt=0, wait_cnt=0,
//   mem_timeout=0, stall_count=0; all outputs take RUN/no-hazard values
//   (all *Write=1, all *Flush=0).
//  load_use = MemRead1 & Rd1!=0 & ((UseRs1 & Rs1==Rd1) | (UseRs2 & Rs2==Rd1)).
//  mem_hold = MemReq & ~MemReady.
//  Priority each cycle (any state): mem_hold > BranchTaken > load_use/LU_STALL.
//  mem_hold (Mealy, same cycle): PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0, no flush;
//   state->MEM_WAIT, previous state saved; wait_cnt increments (saturating).
//   When wait_cnt reaches MEM_TIMEOUT mem_timeout sets; stays 1 until reset; freeze
//   continues. On MemReady: wait_cnt=0, state returns to saved state; LU_STALL
//   resumes with lu_cnt unchanged.
//  BranchTaken (no mem_hold): IFIDFlush=1, IDEXFlush=1, PCWrite=1 (redirect);
//   cancels any load-use stall: state->RUN, lu_cnt=0.
//  RUN + load_use (no higher event): PCWrite=0, IFIDWrite=0, IDEXFlush=1 this cycle.
//   If LOAD_STALL>1: state->LU_STALL, lu_cnt=LOAD_STALL-1.
//  LU_STALL: same outputs as RUN+load_use; lu_cnt decrements; at lu_cnt==1 next
//   state RUN. load_use in final LU_STALL cycle is not re-evaluated.
//  Total load-use penalty = LOAD_STALL cycles; bubbles = LOAD_STALL.
//  stall_count += 1 on every cycle with PCWrite=0 (not in reset); holds at max.
//  Rd1==0 never causes a stall. All state updates on posedge clk only.
//  reset asserted mid-stall or mid-wait: next edge returns to reset values.
// TESTING
//  1 Rs1=3,UseRs1=1,Rd1=3,MemRead1=1 -> 1 cycle PCWrite=0,IFIDWrite=0,IDEXFlush=1; count=1.
//  2 Same as 1 with Rd1=0, or MemRead1=0 -> no stall, all Write=1, count=0.
//  3 LOAD_STALL=3, Rs2=5,UseRs2=1,Rd1=5,load -> exactly 3 bubble cycles, then RUN.
//  4 MemReq=1,MemReady=0 for 4 cycles -> all Write=0 for 4 cycles, then resume; count+=4.
//  5 MEM_TIMEOUT=4, hold MemReady=0 for 6 cycles -> mem_timeout=1 after 4th, sticky.
//  6 BranchTaken=1 with load_use=1 -> IFIDFlush=IDEXFlush=1,PCWrite=1; reset mid-LU_STALL -> RUN.

Source files
------------

// File: rtl/hazard_stall_if.sv
// hazard_stall_if: hazard inputs and pipeline enable/flush outputs; slave = stall unit, master = pipeline side
interface hazard_stall_if #(parameter int CNT_W = 16);
  logic [4:0] Rs1, Rs2, Rd1;
  logic UseRs1, UseRs2, MemRead1, BranchTaken, MemReq, MemReady;
  logic PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite, mem_timeout;
  logic [CNT_W-1:0] stall_count;
  modport slave (
    input  Rs1, Rs2, Rd1, UseRs1, UseRs2, MemRead1, BranchTaken, MemReq, MemReady,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite, mem_timeout, stall_count
  );
  modport master (
    output Rs1, Rs2, Rd1, UseRs1, UseRs2, MemRead1, BranchTaken, MemReq, MemReady,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite, mem_timeout, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use/mem-wait/branch stall-flush control; ports clk, reset (sync high), h (hazard_stall_if.slave)
module hazard_stall_unit #(
  parameter int LOAD_STALL  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic reset,
  hazard_stall_if.slave h
);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
  state_t state_q, state_d, saved_q, saved_d, eff;
  logic [3:0] lu_cnt_q, lu_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load_use, mem_hold, stall, pc_we, lu_start;
  always_comb begin
    load_use = h.MemRead1 && h.Rd1 != 5'd0 &&
               ((h.UseRs1 && h.Rs1 == h.Rd1) || (h.UseRs2 && h.Rs2 == h.Rd1));
    mem_hold = h.MemReq && !h.MemReady;
    // a wait that just completed behaves as the state it interrupted
    eff      = (state_q == MEM_WAIT) ? saved_q : state_q;
    stall    = (eff == LU_STALL) || (eff == RUN && load_use);
    lu_start = eff == RUN && load_use && !h.BranchTaken && LOAD_STALL > 1;
    pc_we    = !mem_hold && (h.BranchTaken || !stall);
    h.PCWrite     = pc_we;
    h.IFIDWrite   = pc_we;
    h.IFIDFlush   = !mem_hold && h.BranchTaken;
    h.IDEXWrite   = !mem_hold;
    h.IDEXFlush   = !mem_hold && (h.BranchTaken || stall);
    h.EXMEMWrite  = !mem_hold;
    h.mem_timeout = timeout_q;
    h.stall_count = cnt_q;
    state_d = mem_hold ? MEM_WAIT :
              h.BranchTaken ? RUN :
              lu_start ? LU_STALL :
              (eff == LU_STALL && lu_cnt_q != 4'd1) ? LU_STALL : RUN;
    saved_d  = (mem_hold && state_q != MEM_WAIT) ? state_q : saved_q;
    lu_cnt_d = mem_hold ? lu_cnt_q :
               h.BranchTaken ? 4'd0 :
               lu_start ? 4'(LOAD_STALL - 1) :
               (eff == LU_STALL) ? lu_cnt_q - 4'd1 : lu_cnt_q;
    wait_cnt_d = !mem_hold ? 8'd0 : (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 8'd1;
    timeout_d  = timeout_q || (mem_hold && wait_cnt_d >= 8'(MEM_TIMEOUT));
    cnt_d      = (!pc_we && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      saved_q    <= RUN;
      lu_cnt_q   <= 4'd0;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed scoreboard bench for two hazard_stall_unit configurations
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  hazard_stall_if #(.CNT_W(16)) ia();
  hazard_stall_if #(.CNT_W(16)) ib();
  hazard_stall_unit #(.LOAD_STALL(3), .MEM_TIMEOUT(4), .CNT_W(16)) ua (.clk(clk), .reset(reset), .h(ia));
  hazard_stall_unit #(.LOAD_STALL(1), .MEM_TIMEOUT(255), .CNT_W(16)) ub (.clk(clk), .reset(reset), .h(ib));
  localparam logic [5:0] RUN_V = 6'b110101, LU_V = 6'b000111, HOLD_V = 6'b000000, BR_V = 6'b111111;
  typedef struct {
    string tag;
    logic [5:0] ctl;
    logic to;
    logic [15:0] cnt;
  } exp_t;
  exp_t qa[$], qb[$];
  int errors = 0, checks = 0;
  task automatic drive(input logic [4:0] rs1, rs2, input logic u1, u2, input logic [4:0] rd1,
                       input logic mr, br, mq, mrdy);
    ia.Rs1 = rs1; ia.Rs2 = rs2; ia.UseRs1 = u1; ia.UseRs2 = u2; ia.Rd1 = rd1;
    ia.MemRead1 = mr; ia.BranchTaken = br; ia.MemReq = mq; ia.MemReady = mrdy;
    ib.Rs1 = rs1; ib.Rs2 = rs2; ib.UseRs1 = u1; ib.UseRs2 = u2; ib.Rd1 = rd1;
    ib.MemRead1 = mr; ib.BranchTaken = br; ib.MemReq = mq; ib.MemReady = mrdy;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp_v);
    end
  endtask
  task automatic step(input string tag, input logic [5:0] ca, input logic ta, input logic [15:0] na,
                      input logic [5:0] cb, input logic tb_, input logic [15:0] nb);
    exp_t e;
    qa.push_back('{tag, ca, ta, na});
    qb.push_back('{tag, cb, tb_, nb});
    @(negedge clk);
    e = qa.pop_front();
    cmp({e.tag, ".a.ctl"}, 16'({ia.PCWrite, ia.IFIDWrite, ia.IFIDFlush, ia.IDEXWrite, ia.IDEXFlush, ia.EXMEMWrite}), 16'(e.ctl));
    cmp({e.tag, ".a.to"}, 16'(ia.mem_timeout), 16'(e.to));
    cmp({e.tag, ".a.cnt"}, ia.stall_count, e.cnt);
    e = qb.pop_front();
    cmp({e.tag, ".b.ctl"}, 16'({ib.PCWrite, ib.IFIDWrite, ib.IFIDFlush, ib.IDEXWrite, ib.IDEXFlush, ib.EXMEMWrite}), 16'(e.ctl));
    cmp({e.tag, ".b.to"}, 16'(ib.mem_timeout), 16'(e.to));
    cmp({e.tag, ".b.cnt"}, ib.stall_count, e.cnt);
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    step("rst", RUN_V, 0, 0, RUN_V, 0, 0);
    reset = 1'b0;
    drive(3, 0, 1, 0, 3, 1, 0, 0, 0); step("ld1", LU_V, 0, 0, LU_V, 0, 0);
    idle(); step("ld2", LU_V, 0, 1, RUN_V, 0, 1);
    idle(); step("ld3", LU_V, 0, 2, RUN_V, 0, 1);
    idle(); step("ldend", RUN_V, 0, 3, RUN_V, 0, 1);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0); step("rd0", RUN_V, 0, 3, RUN_V, 0, 1);
    drive(3, 0, 1, 0, 3, 0, 0, 0, 0); step("noload", RUN_V, 0, 3, RUN_V, 0, 1);
    drive(0, 5, 0, 1, 5, 1, 0, 1, 0); step("h1", HOLD_V, 0, 3, HOLD_V, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("h2", HOLD_V, 0, 4, HOLD_V, 0, 2);
    step("h3", HOLD_V, 0, 5, HOLD_V, 0, 3);
    step("h4", HOLD_V, 0, 6, HOLD_V, 0, 4);
    step("h5", HOLD_V, 1, 7, HOLD_V, 0, 5);
    step("h6", HOLD_V, 1, 8, HOLD_V, 0, 6);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step("hrel", RUN_V, 1, 9, RUN_V, 0, 7);
    idle(); step("sticky", RUN_V, 1, 9, RUN_V, 0, 7);
    drive(0, 5, 0, 1, 5, 1, 0, 0, 0); step("ld_rs2", LU_V, 1, 9, LU_V, 0, 7);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("lu_hold", HOLD_V, 1, 10, HOLD_V, 0, 8);
    idle(); step("lu_resume", LU_V, 1, 11, RUN_V, 0, 9);
    idle(); step("lu_last", LU_V, 1, 12, RUN_V, 0, 9);
    idle(); step("lu_done", RUN_V, 1, 13, RUN_V, 0, 9);
    drive(3, 0, 1, 0, 3, 1, 1, 0, 0); step("br_ld", BR_V, 1, 13, BR_V, 0, 9);
    idle(); step("br_ld_after", RUN_V, 1, 13, RUN_V, 0, 9);
    drive(3, 0, 1, 0, 3, 1, 0, 0, 0); step("ld_b", LU_V, 1, 13, LU_V, 0, 9);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step("br_cancel", BR_V, 1, 14, BR_V, 0, 10);
    idle(); step("br_cancel_after", RUN_V, 1, 14, RUN_V, 0, 10);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0); step("hold_br", HOLD_V, 1, 14, HOLD_V, 0, 10);
    idle(); step("hold_br_after", RUN_V, 1, 15, RUN_V, 0, 11);
    drive(3, 0, 1, 0, 3, 1, 0, 0, 0); step("ld_c", LU_V, 1, 15, LU_V, 0, 11);
    reset = 1'b1;
    idle();
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_rst", RUN_V, 0, 0, RUN_V, 0, 0);
    step("post_rst2", RUN_V, 0, 0, RUN_V, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
